minhash_sketch_accum: RTL and testbench
=======================================

Name: minhash_sketch_accum

Overview:
Downstream of the murmur hasher. Consumes a stream of 32-bit signatures, each tagged with the index of the hash function (seed) that produced it. Keeps a running unsigned minimum per index across one sequence. On end-of-sequence it drains the completed MinHash sketch, one entry per beat, over a valid/ready interface, then re-arms for the next sequence.

Parameters:
HASHER_DATA_BITS, 32, signature width (matches hasher output)
NUM_HASHES, 4, sketch entries / seeds (>=2)
IDX_W, $clog2(NUM_HASHES), seed index width
CNT_W, 16, accepted-signature counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sig_valid  in  1  upstream signature valid
sig_ready  out  1  block accepts signature
sig_data  in  HASHER_DATA_BITS  hasher signature
sig_idx  in  IDX_W  seed index of sig_data
sig_last  in  1  final signature of current sequence
sk_valid  out  1  sketch entry valid
sk_ready  in  1  downstream accepts entry
sk_data  out  HASHER_DATA_BITS  minimum for entry sk_idx
sk_idx  out  IDX_W  sketch entry index
sk_last  out  1  final entry of sketch (sk_idx==NUM_HASHES-1)
sk_count  out  CNT_W  signatures accepted in this sequence (saturating)

Behaviour:
- Single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=ACCUM
  - all min entries = all-ones (MAX_SIG)
  - count=0, drain pointer=0
  - sig_ready=1, sk_valid=0, sk_idx=0, sk_last=0, sk_data=MAX_SIG, sk_count=0
- States:
  - ACCUM: sig_ready=1, sk_valid=0.
  - DRAIN: sig_ready=0, sk_valid=1.
- Accept rule: a signature is accepted when sig_valid&&sig_ready.
  - On the same edge, if sig_idx<NUM_HASHES and sig_data<min[sig_idx] (unsigned), then min[sig_idx]<=sig_data.
  - Equal or greater: no change.
  - sig_idx>=NUM_HASHES: accepted, counted, no array update.
  - count<=count+1, saturating at 2^CNT_W-1.
- ACCUM->DRAIN on an accepted beat with sig_last=1. The update from that beat is visible on the first drain beat, i.e. the next cycle (1-cycle latency).
- sig_last with no prior beats is legal: the sketch holds one update plus MAX_SIG for all other entries.
- DRAIN outputs:
  - sk_idx=drain pointer, sk_data=min[pointer], sk_last=(pointer==NUM_HASHES-1), sk_count=frozen count.
  - All drain outputs stay stable while sk_valid&&!sk_ready.
- On each handshake (sk_valid&&sk_ready): min[pointer]<=MAX_SIG and pointer<=pointer+1.
- On the handshake with sk_last: pointer<=0, count<=0, state<=ACCUM. sig_ready=1 in the following cycle.
- sig_valid during DRAIN is ignored (sig_ready=0). Upstream must hold it per valid/ready rules.
- Outputs are registered or derived only from state/pointer/array. No combinational path from sig_* to sk_*, and none from sk_ready to sig_ready.
- Reset asserted mid-ACCUM or mid-DRAIN: immediate return to reset values. The partial sketch is discarded and no sk beat is emitted.
- Comparison is unsigned, full HASHER_DATA_BITS. An all-ones signature never changes an entry.

Decomposition:
- Package minhash_pkg holds:
  - HASHER_DATA_BITS
  - MAX_SIG = {HASHER_DATA_BITS{1'b1}}
  - the state enum {ACCUM, DRAIN}
  - a sig_beat_t struct {data, idx, last}
- One sub-module: minhash_min_regfile. It owns the NUM_HASHES-entry array with a compare-and-update write port, a read port at the drain pointer, and a per-entry clear-to-MAX_SIG.
- The FSM, counter and handshakes stay in the top.

Test Plan:
- Reset then idle: sig_ready=1, sk_valid=0, sk_data=FFFFFFFF, sk_count=0.
- NUM_HASHES=4. Send (idx,data) = (0,50),(1,20),(0,10),(2,30),(3,40),(1,25,last), no stalls → 4 beats: idx0..3 = 10,20,30,40; sk_last only on idx3; sk_count=6 on all beats; sig_ready=0 during drain, 1 after.
- Single beat (2,0x1234,last) → sketch FFFFFFFF, FFFFFFFF, 0x1234, FFFFFFFF; sk_count=1. A following sequence (0,7,last) drains 7, FFFFFFFF, FFFFFFFF, FFFFFFFF, proving the clear.
- Backpressure: hold sk_ready=0 for 5 cycles on idx1 → sk_idx/sk_data/sk_count stable; no pointer advance; sig_valid high is ignored and then accepted after drain.
- Edge values: data FFFFFFFF leaves an entry unchanged; 80000000 < FFFFFFFF and 00000001 < 80000000 (unsigned); duplicate equal values leave the entry unchanged. With CNT_W=4, send 20 beats → sk_count=15.
- Assert rst_n low asynchronously (between edges) at drain beat 2 → sk_valid drops immediately; after release, sig_ready=1 and the next sequence drains fresh values.

Source files
------------

// File: rtl/minhash_pkg.sv
// rtl/minhash_pkg.sv - shared widths, sentinel and types for the MinHash sketch accumulator
package minhash_pkg;

  localparam int HASHER_DATA_BITS = 32;
  localparam logic [HASHER_DATA_BITS-1:0] MAX_SIG = {HASHER_DATA_BITS{1'b1}};

  // Wide enough to carry any seed index so out-of-range tags can be detected.
  localparam int SIG_IDX_MAX_W = 8;

  typedef enum logic {ACCUM, DRAIN} state_t;

  typedef struct packed {
    logic [HASHER_DATA_BITS-1:0] data;
    logic [SIG_IDX_MAX_W-1:0]    idx;
    logic                        last;
  } sig_beat_t;

endpackage

// File: rtl/minhash_min_regfile.sv
// rtl/minhash_min_regfile.sv - per-seed running minimum array with compare-and-update write,
// drain read port and per-entry clear back to the all-ones sentinel
module minhash_min_regfile
  import minhash_pkg::*;
#(
  parameter int DATA_W = HASHER_DATA_BITS,
  parameter int NUM    = 4,
  parameter int IDX_W  = $clog2(NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) mem[i] <= '1;
    end else begin
      // Clear and update never coincide: one happens only while draining, the other only while accumulating.
      for (int i = 0; i < NUM; i++) begin
        if (clr_en && clr_idx == IDX_W'(i))
          mem[i] <= '1;
        else if (wr_en && wr_idx == IDX_W'(i) && wr_data < mem[i])
          mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/minhash_sketch_accum.sv
// rtl/minhash_sketch_accum.sv - accumulates per-seed minimum signatures over a sequence and
// drains the finished MinHash sketch one entry per beat
module minhash_sketch_accum
  import minhash_pkg::*;
#(
  parameter int HASHER_DATA_BITS = minhash_pkg::HASHER_DATA_BITS,
  parameter int NUM_HASHES       = 4,
  parameter int IDX_W            = $clog2(NUM_HASHES),
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sig_valid,
  output logic                        sig_ready,
  input  logic [HASHER_DATA_BITS-1:0] sig_data,
  input  logic [IDX_W-1:0]            sig_idx,
  input  logic                        sig_last,
  output logic                        sk_valid,
  input  logic                        sk_ready,
  output logic [HASHER_DATA_BITS-1:0] sk_data,
  output logic [IDX_W-1:0]            sk_idx,
  output logic                        sk_last,
  output logic [CNT_W-1:0]            sk_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HASHES - 1);

  state_t                      state;
  sig_beat_t                   beat;
  logic [IDX_W-1:0]            ptr;
  logic [CNT_W-1:0]            count;
  logic [HASHER_DATA_BITS-1:0] rd_data;
  logic                        accept;
  logic                        sk_hs;
  logic                        idx_ok;

  assign beat   = '{data: sig_data, idx: SIG_IDX_MAX_W'(sig_idx), last: sig_last};
  assign accept = sig_valid && sig_ready;
  assign sk_hs  = sk_valid && sk_ready;
  assign idx_ok = beat.idx < SIG_IDX_MAX_W'(NUM_HASHES);

  minhash_min_regfile #(
    .DATA_W (HASHER_DATA_BITS),
    .NUM    (NUM_HASHES),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && idx_ok),
    .wr_idx  (beat.idx[IDX_W-1:0]),
    .wr_data (beat.data),
    .clr_en  (sk_hs),
    .clr_idx (ptr),
    .rd_idx  (ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      ptr       <= '0;
      count     <= '0;
      sig_ready <= 1'b1;
      sk_valid  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (count != '1) count <= count + 1'b1;
            if (beat.last) begin
              state     <= DRAIN;
              sig_ready <= 1'b0;
              sk_valid  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sk_hs) begin
            if (ptr == LAST_IDX) begin
              ptr       <= '0;
              count     <= '0;
              state     <= ACCUM;
              sig_ready <= 1'b1;
              sk_valid  <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign sk_idx   = ptr;
  assign sk_data  = rd_data;
  assign sk_last  = (ptr == LAST_IDX);
  assign sk_count = count;

endmodule

// File: tb/tb_minhash_sketch_accum.sv
// tb/tb_minhash_sketch_accum.sv - bench for minhash_sketch_accum: sequence-level sketch model
// plus directed sequences with literal expected sketches
module tb_minhash_sketch_accum;
  import minhash_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_valid = 1'b0;
  logic [31:0] sig_data = '0;
  logic [1:0]  sig_idx = '0;
  logic        sig_last = 1'b0;
  logic        sk_ready = 1'b1;

  logic        sig_ready, sk_valid, sk_last;
  logic [31:0] sk_data;
  logic [1:0]  sk_idx;
  logic [15:0] sk_count;

  logic        sig_ready4, sk_valid4, sk_last4;
  logic [31:0] sk_data4;
  logic [1:0]  sk_idx4;
  logic [3:0]  sk_count4;

  minhash_sketch_accum #(.NUM_HASHES(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .sig_data(sig_data), .sig_idx(sig_idx), .sig_last(sig_last),
    .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_data(sk_data),
    .sk_idx(sk_idx), .sk_last(sk_last), .sk_count(sk_count)
  );

  minhash_sketch_accum #(.NUM_HASHES(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_valid(sig_valid), .sig_ready(sig_ready4),
    .sig_data(sig_data), .sig_idx(sig_idx), .sig_last(sig_last),
    .sk_valid(sk_valid4), .sk_ready(sk_ready), .sk_data(sk_data4),
    .sk_idx(sk_idx4), .sk_last(sk_last4), .sk_count(sk_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
    int          cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mins[N];
  int          cnt;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap_data[$];
  int          cap_cnt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < N; k++) mins[k] = MAX_SIG;
    q.delete();
    cnt = 0;
  endfunction

  always @(negedge rst_n) model_clear();

  // Outputs sampled at the falling edge; inputs seen here are what the next rising edge will act on.
  always @(negedge clk) begin
    chk("sig_ready", {31'b0, sig_ready}, {31'b0, q.size() == 0});
    chk("sk_valid", {31'b0, sk_valid}, {31'b0, q.size() != 0});
    chk("sig_ready4", {31'b0, sig_ready4}, {31'b0, q.size() == 0});
    chk("sk_valid4", {31'b0, sk_valid4}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("sk_idx", {30'b0, sk_idx}, q[0].idx);
      chk("sk_data", sk_data, q[0].data);
      chk("sk_last", {31'b0, sk_last}, {31'b0, q[0].last});
      chk("sk_count", {16'b0, sk_count}, (q[0].cnt > 65535) ? 65535 : q[0].cnt);
      chk("sk_data4", sk_data4, q[0].data);
      chk("sk_idx4", {30'b0, sk_idx4}, q[0].idx);
      chk("sk_count4", {28'b0, sk_count4}, (q[0].cnt > 15) ? 15 : q[0].cnt);
    end
    if (rst_n && sk_valid && sk_ready) begin
      cap_data.push_back(sk_data);
      cap_cnt.push_back(int'(sk_count));
    end
    if (rst_n) begin
      if (q.size() == 0) begin
        if (sig_valid) begin
          cnt++;
          if (int'(sig_idx) < N && sig_data < mins[sig_idx]) mins[sig_idx] = sig_data;
          if (sig_last) begin
            for (int k = 0; k < N; k++) q.push_back('{mins[k], k, k == N - 1, cnt});
            for (int k = 0; k < N; k++) mins[k] = MAX_SIG;
            cnt = 0;
          end
        end
      end else if (sk_ready) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input int idx, input logic [31:0] d, input bit l);
    int  n = 0;
    bit  done = 0;
    sig_valid = 1'b1;
    sig_idx   = 2'(idx);
    sig_data  = d;
    sig_last  = l;
    while (!done) begin
      @(negedge clk);
      if (sig_ready) done = 1;
      else if (++n > 100) begin
        chk("send_timeout", 32'(n), 32'd0);
        done = 1;
      end
    end
    @(posedge clk); #1;
    sig_valid = 1'b0;
    sig_last  = 1'b0;
  endtask

  task automatic drain_wait(input int beats);
    int n = 0;
    while (cap_data.size() < beats && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cap_data.size() < beats) chk("drain_timeout", 32'(cap_data.size()), 32'(beats));
    @(posedge clk); #1;
  endtask

  task automatic check_caps(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3, input int ecnt);
    chk({nm, "_beats"}, 32'(cap_data.size()), 32'd4);
    if (cap_data.size() >= 4) begin
      chk({nm, "_e0"}, cap_data[0], e0);
      chk({nm, "_e1"}, cap_data[1], e1);
      chk({nm, "_e2"}, cap_data[2], e2);
      chk({nm, "_e3"}, cap_data[3], e3);
      chk({nm, "_cnt0"}, 32'(cap_cnt[0]), 32'(ecnt));
      chk({nm, "_cnt3"}, 32'(cap_cnt[3]), 32'(ecnt));
    end
    cap_data.delete();
    cap_cnt.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sig_ready", {31'b0, sig_ready}, 32'd1);
    chk("rst_sk_valid", {31'b0, sk_valid}, 32'd0);
    chk("rst_sk_data", sk_data, 32'hFFFF_FFFF);
    chk("rst_sk_count", {16'b0, sk_count}, 32'd0);
    chk("rst_sk_idx", {30'b0, sk_idx}, 32'd0);
    chk("rst_sk_last", {31'b0, sk_last}, 32'd0);
    @(posedge clk); #1;

    send(0, 50, 0); send(1, 20, 0); send(0, 10, 0);
    send(2, 30, 0); send(3, 40, 0); send(1, 25, 1);
    drain_wait(4);
    check_caps("basic", 10, 20, 30, 40, 6);
    chk("ready_after_drain", {31'b0, sig_ready}, 32'd1);

    send(2, 32'h1234, 1);
    drain_wait(4);
    check_caps("single", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 1);
    send(0, 7, 1);
    drain_wait(4);
    check_caps("cleared", 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    send(0, 5, 0); send(1, 6, 0); send(2, 7, 0); send(3, 8, 1);
    @(posedge clk); #1;
    sk_ready  = 1'b0;
    sig_valid = 1'b1;
    sig_idx   = 2'd0;
    sig_data  = 99;
    repeat (5) begin
      @(negedge clk);
      chk("stall_idx", {30'b0, sk_idx}, 32'd1);
      chk("stall_data", sk_data, 32'd6);
      chk("stall_count", {16'b0, sk_count}, 32'd4);
      chk("stall_sig_ready", {31'b0, sig_ready}, 32'd0);
    end
    @(posedge clk); #1;
    sk_ready = 1'b1;
    n = 0;
    while (!sig_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("held_sig_accepted", {31'b0, sig_ready}, 32'd1);
    @(posedge clk); #1;
    sig_valid = 1'b0;
    check_caps("stall", 5, 6, 7, 8, 4);
    send(1, 3, 1);
    drain_wait(4);
    check_caps("after_stall", 99, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    send(0, 32'hFFFF_FFFF, 0); send(1, 32'h8000_0000, 0); send(1, 32'hFFFF_FFFF, 0);
    send(2, 32'h8000_0000, 0); send(2, 32'h0000_0001, 0); send(3, 55, 0);
    send(3, 55, 0); send(0, 32'hFFFF_FFFF, 1);
    drain_wait(4);
    check_caps("edge", 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 55, 8);

    for (int i = 0; i < 20; i++) send(i % 4, 32'(1000 - i), i == 19);
    @(negedge clk);
    chk("sat4_count", {28'b0, sk_count4}, 32'd15);
    drain_wait(4);
    check_caps("sat", 984, 983, 982, 981, 20);

    send(0, 1, 0); send(1, 2, 0); send(2, 3, 0); send(3, 4, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sk_valid && sk_idx == 2'd2) && n < 50);
    chk("reach_beat2", {30'b0, sk_idx}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sk_valid", {31'b0, sk_valid}, 32'd0);
    chk("rst_mid_sig_ready", {31'b0, sig_ready}, 32'd1);
    chk("rst_mid_sk_data", sk_data, 32'hFFFF_FFFF);
    chk("rst_mid_sk_idx", {30'b0, sk_idx}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cap_data.delete();
    cap_cnt.delete();
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, sig_ready}, 32'd1);
    send(3, 32'h77, 1);
    drain_wait(4);
    check_caps("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h77, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
